// File: rtl/pipe_tester_if.sv
// pipe_tester_if: stimulus/response and result signals between the tester and the DUT side.
interface pipe_tester_if;
  logic       start;
  logic       x_in, y_in;
  logic       a_out, b_out, c_out, d_out;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_fail_vec;
  modport master (
    input  start, x_in, y_in,
    output a_out, b_out, c_out, d_out, busy, done, pass, err_count, first_fail_vec
  );
  modport slave (
    output start, x_in, y_in,
    input  a_out, b_out, c_out, d_out, busy, done, pass, err_count, first_fail_vec
  );
endinterface

// File: rtl/pipe_tester.sv
// pipe_tester: drives all 16 {a,b,c,d} vectors into a LATENCY-cycle DUT and scores x/y responses.
module pipe_tester #(
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          reset_n,
  pipe_tester_if.master bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;
  state_t             state, state_nx;
  logic [3:0]         vcnt, vcnt_nx;
  logic [2:0]         dcnt;
  logic [LATENCY-1:0] pv;
  logic [3:0]         pvec [LATENCY];
  logic [1:0]         pexp [LATENCY];
  logic               accept, hit, ex;
  logic [4:0]         err_nx;
  assign accept  = bus.start && (state == IDLE || state == DONE);
  assign ex      = (vcnt[3] & vcnt[2]) | vcnt[1];
  assign hit     = pv[LATENCY-1] && ({bus.x_in, bus.y_in} != pexp[LATENCY-1]);
  assign err_nx  = accept ? 5'd0 : bus.err_count + 5'(hit);
  assign vcnt_nx = accept ? 4'd0 : (state == DRIVE ? vcnt + 4'd1 : vcnt);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = accept ? DRIVE : state;
      DRIVE:      state_nx = vcnt == 4'd15 ? DRAIN : DRIVE;
      DRAIN:      state_nx = dcnt == 3'(LATENCY - 1) ? DONE : DRAIN;
      default:    state_nx = IDLE;
    endcase
  end
  // vcnt is the vector on the outputs this cycle; it enters the expectation pipe at the cycle's end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vcnt <= '0;
      dcnt <= '0;
      pv   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pvec[i] <= '0;
        pexp[i] <= '0;
      end
      {bus.a_out, bus.b_out, bus.c_out, bus.d_out} <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail_vec <= '0;
    end else begin
      vcnt    <= vcnt_nx;
      dcnt    <= state == DRAIN ? dcnt + 3'd1 : 3'd0;
      pv      <= accept ? '0 : (pv << 1) | LATENCY'(state == DRIVE);
      pvec[0] <= vcnt;
      pexp[0] <= {ex, ~(vcnt[0] | ex)};
      for (int i = 1; i < LATENCY; i++) begin
        pvec[i] <= pvec[i-1];
        pexp[i] <= pexp[i-1];
      end
      {bus.a_out, bus.b_out, bus.c_out, bus.d_out} <= state_nx == DRIVE ? vcnt_nx : 4'd0;
      bus.busy           <= state_nx == DRIVE || state_nx == DRAIN;
      bus.done           <= state_nx == DONE;
      bus.pass           <= state_nx == DONE && err_nx == 5'd0;
      bus.err_count      <= err_nx;
      bus.first_fail_vec <= accept ? 4'd0 :
                            (hit && bus.err_count == 5'd0) ? pvec[LATENCY-1] : bus.first_fail_vec;
    end
endmodule

// File: tb/tb_pipe_tester.sv
// tb_pipe_tester: directed and random-fault runs of pipe_tester at LATENCY 2 and 4 against modelled DUTs.
module tb_pipe_tester;
  logic        clk = 1'b0, reset_n = 1'b0;
  int          vecs = 0, miss = 0, mode = 0;
  logic [15:0] fx = '0, fy = '0;
  logic [1:0]  p2 [2];
  logic [1:0]  p4 [4];
  pipe_tester_if b2 ();
  pipe_tester_if b4 ();
  pipe_tester #(.LATENCY(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  pipe_tester #(.LATENCY(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));
  always #5 clk = ~clk;
  function automatic logic [1:0] spec_xy(logic [3:0] v);
    logic x;
    x = (v[3] & v[2]) | v[1];
    return {x, ~(v[0] | x)};
  endfunction
  // mode 0 correct, 1 y stuck at 0, 2 x=(a|b)|c, 3 per-vector random flips of x/y
  function automatic logic [1:0] dut_xy(logic [3:0] v);
    logic [1:0] r;
    r = spec_xy(v);
    if (mode == 1) r[0] = 1'b0;
    else if (mode == 2) begin
      r[1] = v[3] | v[2] | v[1];
      r[0] = ~(v[0] | r[1]);
    end else if (mode == 3) r = r ^ {fx[v], fy[v]};
    return r;
  endfunction
  always @(posedge clk) begin
    p2[0] <= dut_xy({b2.a_out, b2.b_out, b2.c_out, b2.d_out});
    p2[1] <= p2[0];
    p4[0] <= dut_xy({b4.a_out, b4.b_out, b4.c_out, b4.d_out});
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign b2.x_in = p2[1][1];
  assign b2.y_in = p2[1][0];
  assign b4.x_in = p4[3][1];
  assign b4.y_in = p4[3][0];
  // packed view: [15:12] abcd, [11] busy, [10] done, [9] pass, [8:4] err_count, [3:0] first_fail_vec
  function automatic logic [15:0] outs(bit big);
    return big ? {b4.a_out, b4.b_out, b4.c_out, b4.d_out, b4.busy, b4.done, b4.pass, b4.err_count, b4.first_fail_vec}
               : {b2.a_out, b2.b_out, b2.c_out, b2.d_out, b2.busy, b2.done, b2.pass, b2.err_count, b2.first_fail_vec};
  endfunction
  task automatic chk(string tag, int obs, int exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic set_start(bit big, logic v);
    if (big) b4.start = v;
    else b2.start = v;
  endtask
  task automatic run(bit big, int glitch);
    int cyc, bc, lat;
    logic [15:0] o;
    cyc = 0;
    bc  = 0;
    lat = big ? 4 : 2;
    @(negedge clk) set_start(big, 1'b1);
    @(negedge clk) set_start(big, 1'b0);
    o = outs(big);
    chk("accept_busy", int'(o[11]), 1);
    chk("accept_done", int'(o[10]), 0);
    while (!o[10] && cyc < 100) begin
      bc += int'(o[11]);
      set_start(big, cyc == glitch);
      @(negedge clk);
      cyc++;
      o = outs(big);
    end
    set_start(big, 1'b0);
    chk("run_len", cyc, 16 + lat);
    chk("busy_len", bc, 16 + lat);
    chk("busy_at_done", int'(o[11]), 0);
  endtask
  task automatic results(bit big, int err, int ffv);
    logic [15:0] o;
    o = outs(big);
    chk("done", int'(o[10]), 1);
    chk("pass", int'(o[9]), int'(err == 0));
    chk("err_count", int'(o[8:4]), err);
    chk("first_fail_vec", int'(o[3:0]), ffv);
    chk("stim_idle", int'(o[15:12]), 0);
  endtask
  task automatic ref_model(output int err, output int ffv);
    err = 0;
    ffv = 0;
    for (int v = 0; v < 16; v++)
      if (dut_xy(4'(v)) != spec_xy(4'(v))) begin
        if (err == 0) ffv = v;
        err++;
      end
  endtask
  initial begin
    int e, f, k;
    logic [15:0] o;
    b2.start = 1'b0;
    b4.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_l2", int'(outs(1'b0)), 0);
    chk("reset_outs_l4", int'(outs(1'b1)), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", int'(outs(1'b0)), 0);
    mode = 0; run(1'b0, -1); results(1'b0, 0, 0);
    mode = 1; run(1'b0, -1); results(1'b0, 3, 0);
    mode = 2; run(1'b0, -1); results(1'b0, 4, 4);
    mode = 0; run(1'b0, 5);  results(1'b0, 0, 0);
    mode = 3;
    for (int t = 0; t < 6; t++) begin
      fx = t == 0 ? 16'hffff : 16'($urandom & $urandom);
      fy = t == 0 ? 16'h0000 : 16'($urandom & $urandom & $urandom);
      ref_model(e, f);
      run(t == 5, -1);
      results(t == 5, e, f);
    end
    mode = 0;
    @(negedge clk) b2.start = 1'b1;
    @(negedge clk) b2.start = 1'b0;
    k = 0;
    o = outs(1'b0);
    while (o[15:12] != 4'd7 && k < 40) begin
      @(negedge clk);
      k++;
      o = outs(1'b0);
    end
    chk("vec7_reached", int'(o[15:12]), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_l2", int'(outs(1'b0)), 0);
    chk("async_reset_l4", int'(outs(1'b1)), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_until_start", int'(outs(1'b0)), 0);
    run(1'b0, -1); results(1'b0, 0, 0);
    run(1'b1, -1); results(1'b1, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
